pe_array_feeder: RTL and testbench
==================================

// Module: pe_array_feeder
// PURPOSE
//  Job-level initiator for the 16-row PE array. Accepts a command (base address, step count, precision, bias),
//  streams act/weight words from the operand SRAM into the array with core_vld/sel_bias/flush control,
//  waits out the array pipeline, then captures the finished PSUM and returns it on a valid/ready result port.
// PARAMETERS
//  ACT_W     `BITS_ACT*`PE_ROW     width of one act word per step
//  WGT_W     `BITS_WEIGHT*`PE_ROW  width of one weight word per step
//  ADDR_W    10                    operand SRAM address width
//  LEN_W     10                    step-count width
//  RES_LAT   3                     cycles from last pe_core_vld=1 until pe_psum holds the final sum
// PORTS
//  CLK            in   1        clock, rising edge
//  RST            in   1        asynchronous reset, active-low
//  cmd_valid      in   1        command offered
//  cmd_ready      out  1        command accepted when cmd_valid&cmd_ready
//  cmd_base_addr  in   ADDR_W   first operand address
//  cmd_len        in   LEN_W    number of accumulation steps
//  cmd_precision  in   4        {act[3:2], wgt[1:0]}: 00=1b, 01=2b, 10=4b, 11=illegal
//  cmd_bias       in   `N_BIAS  bias preloaded into the accumulator
//  mem_rd_en      out  1        SRAM read strobe
//  mem_rd_addr    out  ADDR_W   SRAM read address
//  mem_rd_act     in   ACT_W    act data, valid one cycle after mem_rd_en
//  mem_rd_wgt     in   WGT_W    weight data, valid one cycle after mem_rd_en
//  pe_act         out  ACT_W    to array i_Act (= mem_rd_act, pass-through)
//  pe_weight      out  WGT_W    to array i_Weight (= mem_rd_wgt, pass-through)
//  pe_precision   out  4        to array i_Precision, registered
//  pe_bias        out  `N_BIAS  to array i_Bias, registered
//  pe_sel_bias    out  1        to array i_Sel_Bias
//  pe_flush       out  1        to array i_Flush
//  pe_core_vld    out  1        to array core_vld
//  pe_psum        in   `BITS_PSUM  from array o_Psum
//  res_valid      out  1        result available
//  res_ready      in   1        result consumed when res_valid&res_ready
//  res_data       out  `BITS_PSUM  captured PSUM
//  res_err        out  1        command was illegal; res_data=0
// BEHAVIOUR
//  Reset (RST=0, any cycle, including mid-job): state=IDLE; all outputs 0 except cmd_ready=1 and pe_flush=1;
//   in-flight reads are abandoned and no result is produced.
//  FSM IDLE -> FETCH -> DRAIN -> RESULT -> IDLE; IDLE -> RESULT(err) for illegal commands.
//  IDLE: cmd_ready=1, pe_flush=1. On accept, latch precision, bias, base, len; step=0.
//   Illegal = cmd_len==0 or either precision field ==2'b11 -> go to RESULT with res_err=1, res_data=0,
//   no SRAM reads, pe_precision unchanged.
//  FETCH: mem_rd_en=1, mem_rd_addr=(base+step) mod 2^ADDR_W (wraps); step++ each cycle.
//   After len read cycles -> DRAIN. pe_core_vld = mem_rd_en delayed 1 cycle, aligned with returned data.
//   pe_sel_bias=1 only on the core_vld cycle of step 0; 0 on all other steps.
//  DRAIN: counts RES_LAT cycles after the last pe_core_vld=1; on the final count,
//   res_data<=pe_psum, res_err<=0 -> RESULT.
//  RESULT: res_valid=1; res_data/res_err stable until res_ready=1 -> IDLE. pe_flush=1 (result already held).
//  pe_flush=0 in FETCH/DRAIN only. pe_precision/pe_bias change only on accept, stable for the whole job.
//  cmd_ready=0 outside IDLE; a command held during RESULT is accepted the cycle after the res handshake.
//  Latency for a legal job of len L: accept at cycle 0 -> res_valid at cycle L+RES_LAT+2.
//  len=2^LEN_W-1 is legal; the step counter must not overflow. Address wrap does not affect step count.
// STRUCTURE
//  Shared package/header: precision field encodings, FSM state encodings, RES_LAT default.
//  One sub-module: pe_feeder_addr_gen (base/step counter, wrap, last-step flag). All else in the top.
// TESTING
//  1. base=0x010, len=4, prec=4'b10_10, bias=5 -> reads 0x010..0x013 on consecutive cycles; core_vld 4 cycles;
//     sel_bias only on the first; res_data = model sum + 5; res_valid at cycle 4+RES_LAT+2.
//  2. base=0x3FE, len=4 -> addresses 0x3FE,0x3FF,0x000,0x001; result matches an unwrapped model.
//  3. len=0, or prec=4'b11_00 -> no mem_rd_en; res_valid with res_err=1, res_data=0 two cycles after accept.
//  4. res_ready held 0 for 10 cycles -> res_data stable, cmd_ready=0; back-to-back cmd accepted the cycle after the handshake.
//  5. RST low during FETCH at step 2 of 8 -> next cycle all outputs at reset values; new job runs correctly.
//  6. len=1, prec=4'b00_00, bias=-3 -> one core_vld cycle with sel_bias=1; res_data = dot1b - 3.

Source files
------------

// File: rtl/pe_array_feeder_pkg.sv
// Shared encodings and sizing for the PE-array feeder: operand/psum widths,
// precision field codes, controller states and the default array result latency.
package pe_array_feeder_pkg;

    localparam int PE_ROW      = 16;
    localparam int BITS_ACT    = 4;
    localparam int BITS_WEIGHT = 4;
    localparam int N_BIAS      = 16;
    localparam int BITS_PSUM   = 24;
    localparam int RES_LAT_DEF = 3;

    typedef enum logic [1:0] {
        PREC_1B  = 2'b00,
        PREC_2B  = 2'b01,
        PREC_4B  = 2'b10,
        PREC_BAD = 2'b11
    } prec_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_RESULT
    } state_e;

    // Either half of {act, wgt} carrying the reserved code makes the job unusable.
    function automatic logic prec_illegal(input logic [3:0] prec);
        return (prec[3:2] == PREC_BAD) || (prec[1:0] == PREC_BAD);
    endfunction

endpackage

// File: rtl/pe_feeder_addr_gen.sv
// Operand address generator: walks base..base+len-1 with address wrap and
// reports the first and last step of the walk.
module pe_feeder_addr_gen
    import pe_array_feeder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              first_o,
    output logic              last_o
);

    localparam logic [LEN_W-1:0]  STEP_ONE = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  step_q, step_d;
    logic [LEN_W-1:0]  len_q,  len_d;

    // The step counter stops at len-1, so len = 2^LEN_W-1 never overflows it.
    always_comb begin
        addr_d = addr_q;
        step_d = step_q;
        len_d  = len_q;
        if (load_i) begin
            addr_d = base_i;
            step_d = '0;
            len_d  = len_i;
        end else if (adv_i && !last_o) begin
            addr_d = addr_q + ADDR_ONE;
            step_d = step_q + STEP_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            step_q <= '0;
            len_q  <= '0;
        end else begin
            addr_q <= addr_d;
            step_q <= step_d;
            len_q  <= len_d;
        end
    end

    assign addr_o  = addr_q;
    assign first_o = (step_q == '0);
    assign last_o  = (step_q == len_q - STEP_ONE);

endmodule

// File: rtl/pe_array_feeder.sv
// Job-level initiator for the PE array: fetches operands for one command,
// waits out the array pipeline and returns the finished PSUM on a valid/ready port.
module pe_array_feeder
    import pe_array_feeder_pkg::*;
#(
    parameter int ACT_W   = BITS_ACT * PE_ROW,
    parameter int WGT_W   = BITS_WEIGHT * PE_ROW,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 10,
    parameter int RES_LAT = RES_LAT_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_base_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic [3:0]           cmd_precision,
    input  logic [N_BIAS-1:0]    cmd_bias,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    input  logic [ACT_W-1:0]     mem_rd_act,
    input  logic [WGT_W-1:0]     mem_rd_wgt,
    output logic [ACT_W-1:0]     pe_act,
    output logic [WGT_W-1:0]     pe_weight,
    output logic [3:0]           pe_precision,
    output logic [N_BIAS-1:0]    pe_bias,
    output logic                 pe_sel_bias,
    output logic                 pe_flush,
    output logic                 pe_core_vld,
    input  logic [BITS_PSUM-1:0] pe_psum,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BITS_PSUM-1:0] res_data,
    output logic                 res_err
);

    localparam int CNT_W = $clog2(RES_LAT + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RES_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e               state_q;
    logic [3:0]           prec_q;
    logic [N_BIAS-1:0]    bias_q;
    logic                 rd_en_q;
    logic                 core_vld_q;
    logic                 sel_bias_q;
    logic                 flush_q;
    logic                 cmd_ready_q;
    logic                 res_valid_q;
    logic [BITS_PSUM-1:0] res_data_q;
    logic                 res_err_q;
    logic [CNT_W-1:0]     drain_q;

    logic cmd_bad;
    logic load_job;
    logic step_first;
    logic step_last;

    assign cmd_bad  = (cmd_len == '0) || prec_illegal(cmd_precision);
    assign load_job = (state_q == ST_IDLE) && cmd_valid && !cmd_bad;

    pe_feeder_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk     (CLK),
        .rst_n   (RST),
        .load_i  (load_job),
        .adv_i   (state_q == ST_FETCH),
        .base_i  (cmd_base_addr),
        .len_i   (cmd_len),
        .addr_o  (mem_rd_addr),
        .first_o (step_first),
        .last_o  (step_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            prec_q      <= '0;
            bias_q      <= '0;
            rd_en_q     <= 1'b0;
            core_vld_q  <= 1'b0;
            sel_bias_q  <= 1'b0;
            flush_q     <= 1'b1;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            drain_q     <= '0;
        end else begin
            // SRAM data returns one cycle after the strobe; the array sees it together with core_vld.
            core_vld_q <= rd_en_q;
            sel_bias_q <= rd_en_q && step_first;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_bad) begin
                            res_err_q   <= 1'b1;
                            res_data_q  <= '0;
                            res_valid_q <= 1'b0;
                            state_q     <= ST_RESULT;
                        end else begin
                            prec_q  <= cmd_precision;
                            bias_q  <= cmd_bias;
                            rd_en_q <= 1'b1;
                            flush_q <= 1'b0;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (step_last) begin
                        rd_en_q <= 1'b0;
                        drain_q <= '0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        res_data_q  <= pe_psum;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        flush_q     <= 1'b1;
                        state_q     <= ST_RESULT;
                    end else begin
                        drain_q <= drain_q + CNT_ONE;
                    end
                end
                ST_RESULT: begin
                    // An error result spends one cycle here before being offered.
                    if (!res_valid_q) begin
                        res_valid_q <= 1'b1;
                    end else if (res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign mem_rd_en    = rd_en_q;
    assign pe_act       = mem_rd_act;
    assign pe_weight    = mem_rd_wgt;
    assign pe_precision = prec_q;
    assign pe_bias      = bias_q;
    assign pe_sel_bias  = sel_bias_q;
    assign pe_flush     = flush_q;
    assign pe_core_vld  = core_vld_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_err      = res_err_q;

endmodule

// File: tb/tb_pe_array_feeder.sv
// Bench for pe_array_feeder: SRAM and PE-array behavioural models, directed
// corner jobs plus randomized jobs checked against a dot-product reference.
module tb_pe_array_feeder;
    import pe_array_feeder_pkg::*;

    localparam int ACT_W   = BITS_ACT * PE_ROW;
    localparam int WGT_W   = BITS_WEIGHT * PE_ROW;
    localparam int ADDR_W  = 10;
    localparam int LEN_W   = 10;
    localparam int RES_LAT = 3;
    localparam int DEPTH   = 1 << ADDR_W;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [ADDR_W-1:0]    cmd_base_addr = '0;
    logic [LEN_W-1:0]     cmd_len = '0;
    logic [3:0]           cmd_precision = '0;
    logic [N_BIAS-1:0]    cmd_bias = '0;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_rd_addr;
    logic [ACT_W-1:0]     mem_rd_act;
    logic [WGT_W-1:0]     mem_rd_wgt;
    logic [ACT_W-1:0]     pe_act;
    logic [WGT_W-1:0]     pe_weight;
    logic [3:0]           pe_precision;
    logic [N_BIAS-1:0]    pe_bias;
    logic                 pe_sel_bias;
    logic                 pe_flush;
    logic                 pe_core_vld;
    logic [BITS_PSUM-1:0] pe_psum;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [BITS_PSUM-1:0] res_data;
    logic                 res_err;

    always #5 CLK = ~CLK;

    pe_array_feeder #(
        .ACT_W(ACT_W), .WGT_W(WGT_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .RES_LAT(RES_LAT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base_addr(cmd_base_addr),
        .cmd_len(cmd_len), .cmd_precision(cmd_precision), .cmd_bias(cmd_bias),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_act(mem_rd_act), .mem_rd_wgt(mem_rd_wgt),
        .pe_act(pe_act), .pe_weight(pe_weight), .pe_precision(pe_precision), .pe_bias(pe_bias),
        .pe_sel_bias(pe_sel_bias), .pe_flush(pe_flush), .pe_core_vld(pe_core_vld), .pe_psum(pe_psum),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
    );

    logic [ACT_W-1:0] act_mem [DEPTH];
    logic [WGT_W-1:0] wgt_mem [DEPTH];

    // Operand SRAM: one-cycle read latency.
    always @(posedge CLK) begin
        if (mem_rd_en) begin
            mem_rd_act <= act_mem[mem_rd_addr];
            mem_rd_wgt <= wgt_mem[mem_rd_addr];
        end
    end

    function automatic int field_mask(input logic [1:0] f);
        return (f == 2'b00) ? 1 : (f == 2'b01) ? 3 : 15;
    endfunction

    function automatic int dot(input logic [ACT_W-1:0] a, input logic [WGT_W-1:0] w,
                               input logic [3:0] p);
        int s;
        s = 0;
        for (int i = 0; i < PE_ROW; i++)
            s += (int'(a[4*i +: 4]) & field_mask(p[3:2])) * (int'(w[4*i +: 4]) & field_mask(p[1:0]));
        return s;
    endfunction

    // PE array: accumulate on core_vld, result visible RES_LAT cycles after the last valid.
    logic signed [BITS_PSUM-1:0] acc, psum_p1, psum_p2;
    logic signed [BITS_PSUM-1:0] bias_ext;
    assign bias_ext = {{(BITS_PSUM-N_BIAS){pe_bias[N_BIAS-1]}}, pe_bias};
    always @(posedge CLK) begin
        if (pe_flush)
            acc <= '0;
        else if (pe_core_vld)
            acc <= (pe_sel_bias ? bias_ext : acc) + BITS_PSUM'(dot(pe_act, pe_weight, pe_precision));
        psum_p1 <= acc;
        psum_p2 <= psum_p1;
    end
    assign pe_psum = psum_p2;

    function automatic int model(input int base, input int len, input logic [3:0] p, input int bias);
        int s;
        s = bias;
        for (int i = 0; i < len; i++)
            s += dot(act_mem[(base + i) % DEPTH], wgt_mem[(base + i) % DEPTH], p);
        return s;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] prev_prec = 4'b0000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ":ctl"}, 64'({cmd_ready, pe_flush, mem_rd_en, pe_core_vld, pe_sel_bias, res_valid, res_err}),
            64'(7'b1100000));
        chk({tag, ":dat"}, 64'({mem_rd_addr, pe_precision, pe_bias, res_data}), 64'(0));
    endtask

    task automatic send(input int base, input int len, input logic [3:0] prec, input int bias);
        int t;
        @(negedge CLK);
        cmd_valid     = 1'b1;
        cmd_base_addr = ADDR_W'(base);
        cmd_len       = LEN_W'(len);
        cmd_precision = prec;
        cmd_bias      = N_BIAS'(bias);
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("accept", 64'(cmd_ready), 64'(1));
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input string nm, input int base, input int len, input logic [3:0] prec,
                           input int bias, input int hold, input bit chain);
        int k, nrd, nvld, badaddr, badsel, badprec, bad, e;
        bit ill;
        logic [BITS_PSUM-1:0] e24, rd0;
        logic re0;
        ill = (len == 0) || (prec[3:2] == 2'b11) || (prec[1:0] == 2'b11);
        k = 1; nrd = 0; nvld = 0; badaddr = 0; badsel = 0; badprec = 0;
        while (!res_valid && k < len + 40) begin
            if (mem_rd_en) begin
                if (mem_rd_addr !== ADDR_W'(base + nrd)) badaddr++;
                nrd++;
            end
            if (pe_core_vld) begin
                if (pe_sel_bias !== (nvld == 0)) badsel++;
                nvld++;
            end else if (pe_sel_bias) begin
                badsel++;
            end
            if (pe_precision !== (ill ? prev_prec : prec)) badprec++;
            @(posedge CLK);
            #1;
            k++;
        end
        chk({nm, ":latency"}, 64'(k), 64'(ill ? 2 : len + RES_LAT + 2));
        chk({nm, ":reads"}, 64'(nrd), 64'(ill ? 0 : len));
        chk({nm, ":core_vld"}, 64'(nvld), 64'(ill ? 0 : len));
        chk({nm, ":addr_seq"}, 64'(badaddr), 64'(0));
        chk({nm, ":sel_bias"}, 64'(badsel), 64'(0));
        chk({nm, ":prec"}, 64'(badprec), 64'(0));
        e = ill ? 0 : model(base, len, prec, bias);
        e24 = e[BITS_PSUM-1:0];
        chk({nm, ":err"}, 64'(res_err), 64'(ill));
        chk({nm, ":data"}, 64'(res_data), 64'(e24));
        if (!ill) prev_prec = prec;
        rd0 = res_data;
        re0 = res_err;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            if (!res_valid || res_data !== rd0 || res_err !== re0 || cmd_ready) bad++;
        end
        if (hold > 0) chk({nm, ":hold"}, 64'(bad), 64'(0));
        @(negedge CLK);
        res_ready = 1'b1;
        if (chain) cmd_valid = 1'b1;
        @(posedge CLK);
        #1;
        res_ready = 1'b0;
        chk({nm, ":handshake"}, 64'({res_valid, cmd_ready}), 64'(2'b01));
    endtask

    task automatic job(input string nm, input int base, input int len, input logic [3:0] prec, input int bias);
        send(base, len, prec, bias);
        collect(nm, base, len, prec, bias, 0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, len, bias, bad;
        logic [3:0] prec;
        for (int i = 0; i < DEPTH; i++) begin
            act_mem[i] = {$urandom, $urandom};
            wgt_mem[i] = {$urandom, $urandom};
        end
        repeat (3) @(posedge CLK);
        #1;
        chk_reset_vals("reset");
        @(negedge CLK);
        RST = 1'b1;

        job("basic", 'h010, 4, 4'b1010, 5);
        job("wrap", 'h3FE, 4, 4'b0110, 77);
        job("len0", 'h020, 0, 4'b1010, 9);
        job("prec_bad", 'h020, 3, 4'b1100, 9);
        job("len1", 'h155, 1, 4'b0000, -3);

        // Stalled result with the next command waiting behind it.
        send('h100, 6, 4'b1001, -200);
        cmd_base_addr = ADDR_W'('h200);
        cmd_len       = LEN_W'(5);
        cmd_precision = 4'b0110;
        cmd_bias      = N_BIAS'(1234);
        collect("stall", 'h100, 6, 4'b1001, -200, 10, 1'b1);
        job("chained", 'h200, 5, 4'b0110, 1234);

        // Asynchronous reset in the middle of a fetch.
        send('h080, 8, 4'b1010, 11);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("mid_rst:step2", 64'(mem_rd_addr), 64'('h082));
        RST = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge CLK);
        RST = 1'b1;
        prev_prec = 4'b0000;
        bad = 0;
        repeat (12) begin
            @(negedge CLK);
            if (res_valid || mem_rd_en) bad++;
        end
        chk("mid_rst:quiet", 64'(bad), 64'(0));
        job("post_rst", 'h080, 8, 4'b1010, 11);

        for (int n = 0; n < 10; n++) begin
            base = int'($urandom_range(0, DEPTH - 1));
            len  = int'($urandom_range(1, 24));
            prec = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            if ($urandom_range(0, 5) == 0) prec[1:0] = 2'b11;
            bias = int'($urandom_range(0, 65535)) - 32768;
            job("rand", base, len, prec, bias);
        end

        job("max_len", 'h3F0, (1 << LEN_W) - 1, 4'b1010, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
